// File: rtl/pipe_ctrl_v2.sv
// Pipeline control for the yadan core. It builds the stall mask and the
// per-stage flush strobes, and it arbitrates trap and branch redirects.
// A redirect that arrives while PC is stalled is held until PC can take it.
// A watchdog pulses once when PC has been stalled for STALL_LIMIT cycles.
//
// state | meaning
// IDLE  | no pending redirect; the redirect inputs pass straight to PC
// HOLD  | a redirect is latched and stays presented until PC takes it
module pipe_ctrl_v2 #(
   parameter int NSTAGE      = 5,
   parameter int ADDR_W      = 32,
   parameter int BR_STAGE    = 3,
   parameter int IF_STAGE    = 1,
   parameter int STALL_LIMIT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSTAGE-1:0] stallreq_i,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_addr_i,
   input  logic              trap_flag_i,
   input  logic [ADDR_W-1:0] trap_addr_i,
   output logic [NSTAGE-1:0] stalled_o,
   output logic [NSTAGE-1:0] flush_o,
   output logic              branch_flag_o,
   output logic [ADDR_W-1:0] branch_addr_o,
   output logic              redirect_fire_o,
   output logic              stall_timeout_o
);

   localparam int CNT_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_LIMIT - 1);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
   logic              hold_trap_q, hold_trap_d;
   logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
   logic              wd_done_q, wd_done_d;

   logic              rd_flag;
   logic              rd_trap;
   logic [ADDR_W-1:0] rd_addr;
   logic [NSTAGE-1:0] eff_req;
   logic [NSTAGE-1:0] stall_mask;
   logic [NSTAGE-1:0] flush_mask;
   logic              fire;
   logic              wd_to;

   // Pick the redirect source: live inputs in IDLE, latched one in HOLD (trap may override)
   always_comb begin
      rd_flag = 1'b0;
      rd_trap = 1'b0;
      rd_addr = '0;
      if (state_q == IDLE) begin
         if (trap_flag_i) begin
            rd_flag = 1'b1;
            rd_trap = 1'b1;
            rd_addr = trap_addr_i;
         end else if (branch_flag_i) begin
            rd_flag = 1'b1;
            rd_addr = branch_addr_i;
         end
      end else begin
         rd_flag = 1'b1;
         if (trap_flag_i) begin
            rd_trap = 1'b1;
            rd_addr = trap_addr_i;
         end else begin
            rd_trap = hold_trap_q;
            rd_addr = hold_addr_q;
         end
      end
   end

   // Stall mask: everything at or below the highest effective request is held
   always_comb begin
      logic acc;
      acc     = 1'b0;
      eff_req = stallreq_i;
      eff_req[0] = 1'b0;
      // IF is waiting on a fetch that the redirect makes obsolete anyway
      if (rd_flag) eff_req[IF_STAGE] = 1'b0;
      for (int s = NSTAGE - 1; s >= 0; s--) begin
         acc           = acc | eff_req[s];
         stall_mask[s] = acc;
      end
   end

   // Flush strobes for the stages younger than the redirect source; stall wins
   always_comb begin
      fire       = rd_flag & ~stall_mask[0];
      flush_mask = '0;
      for (int s = 1; s < NSTAGE; s++) begin
         if (rd_trap || s < BR_STAGE) flush_mask[s] = 1'b1;
      end
      if (!fire) flush_mask = '0;
      flush_mask = flush_mask & ~stall_mask;
   end

   // Redirect FSM next state and latch control
   always_comb begin
      state_d     = state_q;
      hold_addr_d = hold_addr_q;
      hold_trap_d = hold_trap_q;
      case (state_q)
         IDLE: begin
            if (rd_flag && stall_mask[0]) begin
               state_d     = HOLD;
               hold_addr_d = rd_addr;
               hold_trap_d = rd_trap;
            end
         end
         HOLD: begin
            if (fire) begin
               state_d = IDLE;
            end else if (trap_flag_i) begin
               // a branch seen here comes from the wrong path; only traps replace
               hold_addr_d = trap_addr_i;
               hold_trap_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Watchdog: saturating count of PC-stall cycles, one pulse per stall episode
   always_comb begin
      wd_to     = stall_mask[0] & (wd_cnt_q == CNT_MAX) & ~wd_done_q;
      wd_cnt_d  = '0;
      wd_done_d = 1'b0;
      if (stall_mask[0]) begin
         wd_cnt_d  = (wd_cnt_q == CNT_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
         wd_done_d = wd_done_q | wd_to;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         hold_addr_q <= '0;
         hold_trap_q <= 1'b0;
         wd_cnt_q    <= '0;
         wd_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_addr_q <= hold_addr_d;
         hold_trap_q <= hold_trap_d;
         wd_cnt_q    <= wd_cnt_d;
         wd_done_q   <= wd_done_d;
      end
   end

   // Outputs are forced quiet while reset is asserted, including the pass-through path
   always_comb begin
      stalled_o       = '0;
      flush_o         = '0;
      branch_flag_o   = 1'b0;
      branch_addr_o   = '0;
      redirect_fire_o = 1'b0;
      stall_timeout_o = 1'b0;
      if (!rst) begin
         stalled_o       = stall_mask;
         flush_o         = flush_mask;
         branch_flag_o   = rd_flag;
         branch_addr_o   = rd_addr;
         redirect_fire_o = fire;
         stall_timeout_o = wd_to;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl_v2.sv
// Directed bench for pipe_ctrl_v2 with a short watchdog limit.
module tb_pipe_ctrl_v2;

   logic        clk;
   logic        rst;
   logic [4:0]  stallreq_i;
   logic        branch_flag_i;
   logic [31:0] branch_addr_i;
   logic        trap_flag_i;
   logic [31:0] trap_addr_i;
   logic [4:0]  stalled_o;
   logic [4:0]  flush_o;
   logic        branch_flag_o;
   logic [31:0] branch_addr_o;
   logic        redirect_fire_o;
   logic        stall_timeout_o;

   typedef struct {
      logic [4:0]  st;
      logic [4:0]  fl;
      logic        bf;
      logic [31:0] ba;
      logic        fire;
      logic        to;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   pipe_ctrl_v2 #(
      .NSTAGE(5), .ADDR_W(32), .BR_STAGE(3), .IF_STAGE(1), .STALL_LIMIT(4)
   ) dut (
      .clk(clk), .rst(rst), .stallreq_i(stallreq_i),
      .branch_flag_i(branch_flag_i), .branch_addr_i(branch_addr_i),
      .trap_flag_i(trap_flag_i), .trap_addr_i(trap_addr_i),
      .stalled_o(stalled_o), .flush_o(flush_o),
      .branch_flag_o(branch_flag_o), .branch_addr_o(branch_addr_o),
      .redirect_fire_o(redirect_fire_o), .stall_timeout_o(stall_timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare at the falling edge.
   task automatic step(input string tag, input logic r, input logic [4:0] sr,
                       input logic bf, input logic [31:0] ba,
                       input logic tf, input logic [31:0] ta,
                       input logic [4:0] e_st, input logic [4:0] e_fl,
                       input logic e_bf, input logic [31:0] e_ba,
                       input logic e_fire, input logic e_to);
      exp_t e;
      rst           = r;
      stallreq_i    = sr;
      branch_flag_i = bf;
      branch_addr_i = ba;
      trap_flag_i   = tf;
      trap_addr_i   = ta;
      exp_q.push_back('{st: e_st, fl: e_fl, bf: e_bf, ba: e_ba, fire: e_fire, to: e_to});
      @(negedge clk);
      e = exp_q.pop_front();
      chk(tag, "stalled", 32'(stalled_o), 32'(e.st));
      chk(tag, "flush",   32'(flush_o), 32'(e.fl));
      chk(tag, "bflag",   32'(branch_flag_o), 32'(e.bf));
      chk(tag, "baddr",   branch_addr_o, e.ba);
      chk(tag, "fire",    32'(redirect_fire_o), 32'(e.fire));
      chk(tag, "timeout", 32'(stall_timeout_o), 32'(e.to));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst           = 1'b1;
      stallreq_i    = '0;
      branch_flag_i = 1'b0;
      branch_addr_i = '0;
      trap_flag_i   = 1'b0;
      trap_addr_i   = '0;
      @(posedge clk);
      #1;

      // busy inputs while in reset: outputs must stay quiet
      step("rst_hold", 1, 5'b11111, 1, 32'h1234, 1, 32'h5678, 5'b00000, 5'b00000, 0, 32'h0, 0, 0);

      // 1: stall mask shape
      step("t1_ex",  0, 5'b01000, 0, 0, 0, 0, 5'b01111, 5'b00000, 0, 32'h0, 0, 0);
      step("t1_mix", 0, 5'b10100, 0, 0, 0, 0, 5'b11111, 5'b00000, 0, 32'h0, 0, 0);
      step("t1_clr", 0, 5'b00000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h0, 0, 0);

      // 2: IF stall is dropped under a redirect, which fires at once
      step("t2_ifbr",   0, 5'b00010, 1, 32'h8000_0040, 0, 0, 5'b00000, 5'b00110, 1, 32'h8000_0040, 1, 0);
      step("t2_ifonly", 0, 5'b00010, 0, 0, 0, 0, 5'b00011, 5'b00000, 0, 32'h0, 0, 0);
      step("t2_clr",    0, 5'b00000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h0, 0, 0);

      // 3: branch under ID stall is held, a later branch is ignored, fires when free
      step("t3_enter", 0, 5'b00100, 1, 32'h100, 0, 0, 5'b00111, 5'b00000, 1, 32'h100, 0, 0);
      step("t3_nbr",   0, 5'b00100, 1, 32'h999, 0, 0, 5'b00111, 5'b00000, 1, 32'h100, 0, 0);
      step("t3_hold",  0, 5'b00100, 0, 0, 0, 0, 5'b00111, 5'b00000, 1, 32'h100, 0, 0);
      step("t3_fire",  0, 5'b00000, 0, 0, 0, 0, 5'b00000, 5'b00110, 1, 32'h100, 1, 0);
      step("t3_idle",  0, 5'b00000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h0, 0, 0);

      // 4: trap replaces a held branch and flushes as a trap
      step("t4_enter", 0, 5'b00100, 1, 32'h100, 0, 0, 5'b00111, 5'b00000, 1, 32'h100, 0, 0);
      step("t4_trap",  0, 5'b00100, 0, 0, 1, 32'h200, 5'b00111, 5'b00000, 1, 32'h200, 0, 0);
      step("t4_held",  0, 5'b00100, 0, 0, 0, 0, 5'b00111, 5'b00000, 1, 32'h200, 0, 0);
      step("t4_fire",  0, 5'b00000, 0, 0, 0, 0, 5'b00000, 5'b11110, 1, 32'h200, 1, 0);

      // 5: simultaneous trap and branch in IDLE
      step("t5_both", 0, 5'b00000, 1, 32'h100, 1, 32'h200, 5'b00000, 5'b11110, 1, 32'h200, 1, 0);
      step("t5_idle", 0, 5'b00000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h0, 0, 0);

      // 6: watchdog pulses once in cycle 4 of a long stall, then re-arms
      for (int i = 1; i <= 6; i++)
         step("t6_wd", 0, 5'b10000, 0, 0, 0, 0, 5'b11111, 5'b00000, 0, 32'h0, 0, (i == 4));
      step("t6_clr", 0, 5'b00000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h0, 0, 0);
      for (int i = 1; i <= 4; i++)
         step("t6_rearm", 0, 5'b10000, 0, 0, 0, 0, 5'b11111, 5'b00000, 0, 32'h0, 0, (i == 4));
      step("t6_clr2", 0, 5'b00000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h0, 0, 0);

      // reset in HOLD drops the pending redirect
      step("r_enter", 0, 5'b00100, 1, 32'h300, 0, 0, 5'b00111, 5'b00000, 1, 32'h300, 0, 0);
      step("r_async", 1, 5'b00100, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h0, 0, 0);
      step("r_idle",  0, 5'b00000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h0, 0, 0);

      chk("end", "queue", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
